// File: rtl/rd_port_40x64b_1_to_8_arb_pkg.sv
// Shared register-file read/write port constants, tracking-entry type and helpers.
// Also used by the 8-to-1 write-port mux.
package rd_port_40x64b_1_to_8_arb_pkg;

  localparam int unsigned NumRdPorts = 8;
  localparam int unsigned RfDepth    = 40;
  localparam int unsigned RfAddrW    = 6;
  localparam int unsigned RfDataW    = 64;
  localparam int unsigned PtrW       = $clog2(NumRdPorts);

  typedef logic [NumRdPorts-1:0] port_oh_t;
  typedef logic [RfAddrW-1:0]    rf_addr_t;
  typedef logic [RfDataW-1:0]    rf_data_t;
  typedef logic [PtrW-1:0]       port_idx_t;

  // One in-flight read: requester tag (all-zero for an idle slot), address, range error.
  typedef struct packed {
    port_oh_t tag;
    rf_addr_t addr;
    logic     err;
  } trk_t;

  function automatic port_idx_t oh_to_idx(input port_oh_t oh);
    port_idx_t idx;
    idx = '0;
    for (int unsigned k = 0; k < NumRdPorts; k++) begin
      if (oh[k]) idx = idx | PtrW'(k);
    end
    return idx;
  endfunction

  function automatic logic addr_oob(input rf_addr_t addr);
    return addr >= RfAddrW'(RfDepth);
  endfunction

endpackage

// File: rtl/rd_port_40x64b_1_to_8_arb_rr_arb_8.sv
// Combinational 8-way round-robin arbiter: first asserted request at or after the
// pointer (wrapping) wins. The pointer register lives in the parent.
module rr_arb_8
  import rd_port_40x64b_1_to_8_arb_pkg::*;
(
  input  logic [NumRdPorts-1:0] req_i,
  input  logic [PtrW-1:0]       ptr_i,
  output logic [NumRdPorts-1:0] gnt_o
);

  always_comb begin
    logic            found;
    logic [PtrW-1:0] idx;
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NumRdPorts; i++) begin
      idx = ptr_i + PtrW'(i);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_port_40x64b_1_to_8_arb.sv
// 8-requester read port for a 40x64b register file: round-robin issue, latency tracking
// and one-hot response return. Define RD_PORT_WR_BYPASS_EN for write-to-read forwarding.
module rd_port_40x64b_1_to_8_arb
  import rd_port_40x64b_1_to_8_arb_pkg::*;
#(
  parameter int unsigned RdLatency = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumRdPorts-1:0]     req_i,
  input  logic [NumRdPorts*RfAddrW-1:0] req_addr_i,
  output logic [NumRdPorts-1:0]     gnt_o,
  output logic                      rf_rd_en_o,
  output logic [RfAddrW-1:0]        rf_rd_addr_o,
  input  logic [RfDataW-1:0]        rf_rd_data_i,
`ifdef RD_PORT_WR_BYPASS_EN
  input  logic                      wr_en_i,
  input  logic [RfAddrW-1:0]        wr_addr_i,
  input  logic [RfDataW-1:0]        wr_data_i,
`endif
  output logic [NumRdPorts-1:0]     rsp_valid_o,
  output logic [RfDataW-1:0]        rsp_data_o,
  output logic                      rsp_err_o
);

  port_idx_t ptr_q, ptr_d;
  port_oh_t  arb_gnt;
  rf_addr_t  grant_addr;
  rf_addr_t  rf_rd_addr_q;
  trk_t      issue;
  trk_t      head;
  trk_t      pipe_q [RdLatency];

  port_oh_t  rsp_valid_q, rsp_valid_d;
  rf_data_t  rsp_data_q, rsp_data_d;
  logic      rsp_err_q, rsp_err_d;

  rr_arb_8 u_rr_arb_8 (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // Grant is combinational but must read as zero while reset is held.
  assign gnt_o      = rst_ni ? arb_gnt : '0;
  assign rf_rd_en_o = |gnt_o;

  always_comb begin
    grant_addr = '0;
    for (int unsigned k = 0; k < NumRdPorts; k++) begin
      if (gnt_o[k]) grant_addr = req_addr_i[RfAddrW*k +: RfAddrW];
    end
  end

  assign rf_rd_addr_o = rf_rd_en_o ? grant_addr : rf_rd_addr_q;
  assign ptr_d        = rf_rd_en_o ? oh_to_idx(gnt_o) + PtrW'(1) : ptr_q;

  always_comb begin
    issue.tag  = gnt_o;
    issue.addr = grant_addr;
    issue.err  = rf_rd_en_o && addr_oob(grant_addr);
  end

  assign head = pipe_q[RdLatency-1];

  always_comb begin
    rsp_valid_d = head.tag;
    rsp_err_d   = head.err;
    rsp_data_d  = rsp_data_q;
    if (|head.tag) begin
      rsp_data_d = head.err ? '0 : rf_rd_data_i;
`ifdef RD_PORT_WR_BYPASS_EN
      if (wr_en_i && (wr_addr_i == head.addr) && !head.err) rsp_data_d = wr_data_i;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q        <= '0;
      rf_rd_addr_q <= '0;
      for (int unsigned i = 0; i < RdLatency; i++) pipe_q[i] <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (rf_rd_en_o) rf_rd_addr_q <= grant_addr;
      pipe_q[0] <= issue;
      for (int unsigned i = 1; i < RdLatency; i++) pipe_q[i] <= pipe_q[i-1];
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_rd_port_40x64b_1_to_8_arb.sv
// Scoreboard bench: a latency-1 and a latency-3 instance, each with its own file model
// and response monitor.
module tb_rd_port_40x64b_1_to_8_arb;

  typedef struct {
    logic [7:0]  oh;
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  logic [63:0] mem [64];
  exp_t        q1 [$];
  exp_t        q3 [$];
  logic [5:0]  last1 = '0;
  logic [5:0]  last3 = '0;

  logic [7:0]  req1, gnt1, vld1, req3, gnt3, vld3;
  logic [47:0] addr1, addr3;
  logic        en1, err1, en3, err3;
  logic [5:0]  raddr1, raddr3;
  logic [63:0] rdata1, rdat1, rdata3, rdat3;
  logic [63:0] p1;
  logic [63:0] p3 [3];
`ifdef RD_PORT_WR_BYPASS_EN
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
`endif

  rd_port_40x64b_1_to_8_arb #(.RdLatency(1)) dut1 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req1),
    .req_addr_i   (addr1),
    .gnt_o        (gnt1),
    .rf_rd_en_o   (en1),
    .rf_rd_addr_o (raddr1),
    .rf_rd_data_i (rdata1),
`ifdef RD_PORT_WR_BYPASS_EN
    .wr_en_i      (wr_en),
    .wr_addr_i    (wr_addr),
    .wr_data_i    (wr_data),
`endif
    .rsp_valid_o  (vld1),
    .rsp_data_o   (rdat1),
    .rsp_err_o    (err1)
  );

  rd_port_40x64b_1_to_8_arb #(.RdLatency(3)) dut3 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req3),
    .req_addr_i   (addr3),
    .gnt_o        (gnt3),
    .rf_rd_en_o   (en3),
    .rf_rd_addr_o (raddr3),
    .rf_rd_data_i (rdata3),
`ifdef RD_PORT_WR_BYPASS_EN
    .wr_en_i      (1'b0),
    .wr_addr_i    (6'd0),
    .wr_data_i    (64'd0),
`endif
    .rsp_valid_o  (vld3),
    .rsp_data_o   (rdat3),
    .rsp_err_o    (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register-file models with 1 and 3 cycles of read latency.
  always @(posedge clk) begin
    if (en1) p1 <= mem[raddr1];
    p3[0] <= en3 ? mem[raddr3] : 64'h0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata1 = p1;
  assign rdata3 = p3[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (vld1 != 8'h0) begin
      if (q1.size() == 0) chk("rsp1_unexpected", {56'h0, vld1}, 64'h0);
      else begin
        e = q1.pop_front();
        chk("rsp1_valid", {56'h0, vld1}, {56'h0, e.oh});
        chk("rsp1_data", rdat1, e.data);
        chk("rsp1_err", {63'h0, err1}, {63'h0, e.err});
        chk("rsp1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (vld3 != 8'h0) begin
      if (q3.size() == 0) chk("rsp3_unexpected", {56'h0, vld3}, 64'h0);
      else begin
        e = q3.pop_front();
        chk("rsp3_valid", {56'h0, vld3}, {56'h0, e.oh});
        chk("rsp3_data", rdat3, e.data);
        chk("rsp3_err", {63'h0, err3}, {63'h0, e.err});
        chk("rsp3_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Entered at posedge+1; checks issue at the negedge, leaves at next posedge+1.
  task automatic drive1(input logic [7:0] r, input logic [47:0] a, input logic [7:0] eg,
                        input logic [63:0] ed, input logic ee, input bit push);
    exp_t       e;
    logic [5:0] ea;
    req1 = r;
    addr1 = a;
    @(negedge clk);
    chk("gnt1", {56'h0, gnt1}, {56'h0, eg});
    chk("rd_en1", {63'h0, en1}, {63'h0, (eg != 8'h0)});
    ea = last1;
    for (int k = 0; k < 8; k++) if (eg[k]) ea = a[6*k +: 6];
    chk("rd_addr1", {58'h0, raddr1}, {58'h0, ea});
    last1 = ea;
    if (eg != 8'h0 && push) begin
      e.oh = eg; e.data = ed; e.err = ee; e.cyc = cyc + 2;
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic [7:0] r, input logic [47:0] a, input logic [7:0] eg,
                        input logic [63:0] ed);
    exp_t       e;
    logic [5:0] ea;
    req3 = r;
    addr3 = a;
    @(negedge clk);
    chk("gnt3", {56'h0, gnt3}, {56'h0, eg});
    ea = last3;
    for (int k = 0; k < 8; k++) if (eg[k]) ea = a[6*k +: 6];
    chk("rd_addr3", {58'h0, raddr3}, {58'h0, ea});
    last3 = ea;
    if (eg != 8'h0) begin
      e.oh = eg; e.data = ed; e.err = 1'b0; e.cyc = cyc + 4;
      q3.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle1(input int n);
    for (int i = 0; i < n; i++) drive1(8'h0, 48'h0, 8'h0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_gnt"}, {56'h0, gnt1}, 64'h0);
    chk({tag, "_rd_en"}, {63'h0, en1}, 64'h0);
    chk({tag, "_rd_addr"}, {58'h0, raddr1}, 64'h0);
    chk({tag, "_rsp_valid"}, {56'h0, vld1}, 64'h0);
    chk({tag, "_rsp_data"}, rdat1, 64'h0);
    chk({tag, "_rsp_err"}, {63'h0, err1}, 64'h0);
    chk({tag, "_gnt3"}, {56'h0, gnt3}, 64'h0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    req1 = 8'h0;
    req3 = 8'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    last1 = '0;
    last3 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [47:0] a;
    for (int i = 0; i < 64; i++) mem[i] = 64'hC0DE_0000_0000_0000 | 64'(i);
    mem[5] = 64'hDEAD_BEEF_0000_0005;
`ifdef RD_PORT_WR_BYPASS_EN
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
`endif
    // Reset with every port requesting: all outputs must read zero.
    rst_n = 1'b0;
    req1 = 8'hFF; addr1 = 48'hFFFF_FFFF_FFFF;
    req3 = 8'hFF; addr3 = 48'hFFFF_FFFF_FFFF;
    #3;
    check_zero_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    req1 = 8'h0; req3 = 8'h0;
    rst_n = 1'b1;

    // Single requester, port 3, address 5.
    drive1(8'h08, 48'(5) << 18, 8'h08, 64'hDEAD_BEEF_0000_0005, 1'b0, 1'b1);
    idle1(3);

    // All eight requesting from reset: grants rotate 0..7.
    pulse_reset();
    a = '0;
    for (int k = 0; k < 8; k++) a[6*k +: 6] = 6'(10 + k);
    for (int i = 0; i < 8; i++)
      drive1(8'hFF, a, 8'(1 << i), 64'hC0DE_0000_0000_0000 + 64'(10 + i), 1'b0, 1'b1);
    idle1(2);

    // Out-of-range address on port 6: issued, data forced to zero, error flagged.
    drive1(8'h40, 48'(45) << 36, 8'h40, 64'h0, 1'b1, 1'b1);
    idle1(2);

    // Port 0 reads entry 9 while entry 9 is written in the response cycle.
`ifdef RD_PORT_WR_BYPASS_EN
    drive1(8'h01, 48'd9, 8'h01, 64'h1234, 1'b0, 1'b1);
    wr_en = 1'b1; wr_addr = 6'd9; wr_data = 64'h1234;
    idle1(1);
    wr_en = 1'b0;
`else
    drive1(8'h01, 48'd9, 8'h01, 64'hC0DE_0000_0000_0009, 1'b0, 1'b1);
    idle1(1);
`endif
    idle1(2);

    // Ports 1 and 2 back to back, then reset kills both in-flight reads.
    a = '0;
    a[11:6] = 6'd3;
    a[17:12] = 6'd4;
    drive1(8'h06, a, 8'h02, 64'h0, 1'b0, 1'b0);
    drive1(8'h04, a, 8'h04, 64'h0, 1'b0, 1'b0);
    a = '0;
    a[5:0] = 6'd7;
    a[23:18] = 6'd8;
    req1 = 8'h09; addr1 = a;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    @(posedge clk);
    #1;
    req1 = 8'h0;
    rst_n = 1'b1;
    last1 = '0;
    for (int i = 0; i < 4; i++) begin
      idle1(1);
      chk("no_rsp_after_rst", {56'h0, vld1}, 64'h0);
    end
    // Pointer back at 0: port 0 beats port 3.
    drive1(8'h09, a, 8'h01, 64'hC0DE_0000_0000_0007, 1'b0, 1'b1);
    drive1(8'h08, a, 8'h08, 64'hC0DE_0000_0000_0008, 1'b0, 1'b1);
    // Pointer at 4: port 7 wins before wrapping, then port 0.
    a[47:42] = 6'd30;
    drive1(8'h81, a, 8'h80, 64'hC0DE_0000_0000_001E, 1'b0, 1'b1);
    drive1(8'h81, a, 8'h01, 64'hC0DE_0000_0000_0007, 1'b0, 1'b1);
    idle1(3);

    // Latency-3 instance: port 4 streaming for 10 cycles.
    for (int i = 0; i < 10; i++)
      drive3(8'h10, 48'(20 + i) << 24, 8'h10, 64'hC0DE_0000_0000_0000 + 64'(20 + i));
    for (int i = 0; i < 6; i++) drive3(8'h0, 48'h0, 8'h0, 64'h0);

    chk("q1_drained", 64'(q1.size()), 64'h0);
    chk("q3_drained", 64'(q3.size()), 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
